seq_event_counter: RTL

Downstream consumer of the sequence detector's Mealy output `z`. Counts detections in a two-digit BCD counter (00–99) and drives two active-low seven-segment digits. Stretches each detection into a visible LED pulse and flags counter wrap with a sticky overflow bit. Sits between the detector and the board display/LED pins.

---
 rtl/seq_event_counter.sv | 104 ++++++++++
 1 files changed

// File: rtl/seq_event_counter.sv
// seq_event_counter: BCD detection counter with 7-seg decode, stretched LED and sticky overflow.
// Define SEQ_CNT_EDGE_EN to count rising edges of z instead of high levels.
module seq_event_counter #(
   parameter int STRETCH_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       z,
   input  logic       clear,
   input  logic       hold,
   output logic [3:0] count_ones,
   output logic [3:0] count_tens,
   output logic [6:0] hex0,
   output logic [6:0] hex1,
   output logic       led,
   output logic       overflow
);
   typedef enum logic [1:0] {IDLE = 2'b01, STRETCH = 2'b10} state_t;
   localparam logic [7:0] RELOAD = 8'(STRETCH_CYCLES - 1);
   state_t     state, state_n;
   logic [7:0] timer, timer_n;
   logic       detect;
`ifdef SEQ_CNT_EDGE_EN
   logic z_prev;
   always_ff @(posedge clk or posedge rst)
      if (rst) z_prev <= 1'b0;
      else     z_prev <= z;
   assign detect = z & ~z_prev & ~hold;
`else
   assign detect = z & ~hold;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_ones <= 4'd0;
         count_tens <= 4'd0;
         overflow   <= 1'b0;
      end else if (clear) begin
         count_ones <= 4'd0;
         count_tens <= 4'd0;
         overflow   <= 1'b0;
      end else if (detect) begin
         if (count_ones != 4'd9) count_ones <= count_ones + 4'd1;
         else begin
            count_ones <= 4'd0;
            if (count_tens != 4'd9) count_tens <= count_tens + 4'd1;
            else begin
               count_tens <= 4'd0;
               overflow   <= 1'b1;
            end
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         timer <= 8'd0;
      end else begin
         state <= state_n;
         timer <= timer_n;
      end
   end
   always_comb begin
      state_n = state;
      timer_n = timer;
      if (clear) begin
         state_n = IDLE;
         timer_n = 8'd0;
      end else begin
         case (state)
            IDLE:
               if (detect) begin
                  state_n = STRETCH;
                  timer_n = RELOAD;
               end
            STRETCH:
               if (detect) timer_n = RELOAD;
               else if (timer == 8'd0) state_n = IDLE;
               else timer_n = timer - 8'd1;
            default: begin
               state_n = IDLE;
               timer_n = 8'd0;
            end
         endcase
      end
   end
   assign led = (state == STRETCH);
   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = 7'b1111111;
      endcase
   endfunction
   assign hex0 = seg(count_ones);
   assign hex1 = seg(count_tens);
endmodule
